// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - BCD round countdown timer driven by a synchronized slow_clk tick
// Ticks come from rising edges of slow_clk sampled as data; the count is kept as two BCD digits.
module game_countdown_timer #(
  parameter int START_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       paused,
  output logic       time_up,
  output logic       time_up_pulse
);

  localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
  localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t state;
  logic   s1;
  logic   s2;
  logic   prev;
  logic   tick;
  logic   at_one;

  // slow_clk is asynchronous to clk: two flops before the edge detector
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= slow_clk;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign tick   = s2 & ~prev;
  assign at_one = (tens == 4'd0) && (ones == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tens          <= START_TENS;
      ones          <= START_ONES;
      running       <= 1'b0;
      paused        <= 1'b0;
      time_up       <= 1'b0;
      time_up_pulse <= 1'b0;
    end else begin
      time_up_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick && at_one) begin
            // reaching zero takes priority over a simultaneous pause
            ones          <= 4'd0;
            state         <= DONE;
            running       <= 1'b0;
            time_up       <= 1'b1;
            time_up_pulse <= 1'b1;
          end else begin
            if (tick) begin
              if (ones != 4'd0) begin
                ones <= ones - 4'd1;
              end else begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
              end
            end
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
              paused  <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state   <= RUN;
            running <= 1'b1;
            paused  <= 1'b0;
          end
        end
        DONE: begin
          if (start) begin
            tens    <= START_TENS;
            ones    <= START_ONES;
            state   <= RUN;
            running <= 1'b1;
            time_up <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          paused  <= 1'b0;
          time_up <= 1'b0;
        end
      endcase
    end
  end

endmodule
